// File: rtl/mod_counter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mod_counter_pkg: shared mode encoding and direction constants. Rev 1.0
// ------------------------------------------------------------------
package mod_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mod_counter_prescaler.sv
`default_nettype none
// ------------------------------------------------------------------
// mod_counter_prescaler: divides enabled cycles by presc+1. Rev 1.0
// ------------------------------------------------------------------
module mod_counter_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] count;

  assign tick = enable && (count == presc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + PRESC_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// mod_counter: up/down/ping-pong modulo counter with terminal-count pulse.
// Optional prescaler enabled by MOD_COUNTER_PRESCALE_EN. Rev 1.0
// ------------------------------------------------------------------
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_value,
  input  logic [WIDTH-1:0]   max,
  input  logic [1:0]         mode,
`ifdef MOD_COUNTER_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc,
`endif
  output logic [WIDTH-1:0]   value,
  output logic               dir,
  output logic               tc
);

  mode_e            mode_sel;
  logic             tick;
  logic             step;
  logic [WIDTH-1:0] max_m1;
  logic [WIDTH-1:0] max_m2;
  logic [WIDTH-1:0] value_nxt;
  logic             dir_nxt;
  logic             tc_nxt;

  assign mode_sel = mode_e'(mode);

`ifdef MOD_COUNTER_PRESCALE_EN
  mod_counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (load),
    .presc  (presc),
    .tick   (tick)
  );
`else
  logic unused_presc_w;
  assign unused_presc_w = ^PRESC_W;
  assign tick           = 1'b1;
`endif

  assign step   = enable & tick;
  // Only consumed under guards that rule out underflow.
  assign max_m1 = max - WIDTH'(1);
  assign max_m2 = max - WIDTH'(2);

  always_comb begin
    value_nxt = value;
    dir_nxt   = dir;
    tc_nxt    = 1'b0;
    if (load) begin
      value_nxt = ((max == '0) || (load_value >= max)) ? '0 : load_value;
      dir_nxt   = (mode_sel == MODE_DOWN);
    end else if (step && (mode_sel != MODE_HOLD)) begin
      if (max == '0) begin
        value_nxt = '0;
      end else if (max == WIDTH'(1)) begin
        value_nxt = '0;
        tc_nxt    = 1'b1;
        case (mode_sel)
          MODE_PINGPONG: dir_nxt = ~dir;
          MODE_DOWN:     dir_nxt = DIR_DOWN;
          default:       dir_nxt = DIR_UP;
        endcase
      end else if (value >= max) begin
        tc_nxt = 1'b1;
        if (mode_sel == MODE_UP) begin
          value_nxt = '0;
          dir_nxt   = DIR_UP;
        end else begin
          value_nxt = max_m1;
          dir_nxt   = DIR_DOWN;
        end
      end else begin
        case (mode_sel)
          MODE_UP: begin
            dir_nxt = DIR_UP;
            if (value == max_m1) begin
              value_nxt = '0;
              tc_nxt    = 1'b1;
            end else begin
              value_nxt = value + WIDTH'(1);
            end
          end
          MODE_DOWN: begin
            dir_nxt = DIR_DOWN;
            if (value == '0) begin
              value_nxt = max_m1;
              tc_nxt    = 1'b1;
            end else begin
              value_nxt = value - WIDTH'(1);
            end
          end
          default: begin
            if ((dir == DIR_UP) && (value == max_m1)) begin
              value_nxt = max_m2;
              dir_nxt   = DIR_DOWN;
              tc_nxt    = 1'b1;
            end else if ((dir == DIR_DOWN) && (value == '0)) begin
              value_nxt = WIDTH'(1);
              dir_nxt   = DIR_UP;
              tc_nxt    = 1'b1;
            end else if (dir == DIR_UP) begin
              value_nxt = value + WIDTH'(1);
            end else begin
              value_nxt = value - WIDTH'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      dir   <= DIR_UP;
      tc    <= 1'b0;
    end else begin
      value <= value_nxt;
      dir   <= dir_nxt;
      tc    <= tc_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mod_counter: directed and randomized checks of mod_counter. Rev 1.0
// ------------------------------------------------------------------
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic [7:0] max = 8'd0;
  logic [1:0] mode = 2'b00;
  logic [7:0] presc = 8'd0;
  logic [7:0] value;
  logic       dir;
  logic       tc;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state, integer arithmetic
  int m_v = 0;
  int m_d = 0;
  int m_t = 0;
  int m_pc = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .PRESC_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .max        (max),
    .mode       (mode),
`ifdef MOD_COUNTER_PRESCALE_EN
    .presc      (presc),
`endif
    .value      (value),
    .dir        (dir),
    .tc         (tc)
  );

  always @(posedge clk or posedge reset) begin
    int mx;
    int step;
    if (reset) begin
      m_v = 0; m_d = 0; m_t = 0; m_pc = 0;
    end else begin
      mx = int'(max);
`ifdef MOD_COUNTER_PRESCALE_EN
      step = (enable && m_pc == int'(presc)) ? 1 : 0;
      if (load) m_pc = 0;
      else if (enable) m_pc = (m_pc == int'(presc)) ? 0 : m_pc + 1;
`else
      step = enable ? 1 : 0;
`endif
      m_t = 0;
      if (load) begin
        m_v = (mx == 0 || int'(load_value) >= mx) ? 0 : int'(load_value);
        m_d = (mode == 2'b01) ? 1 : 0;
      end else if (step == 1 && mode != 2'b11) begin
        if (mx == 0) begin
          m_v = 0;
        end else if (mx == 1) begin
          m_v = 0; m_t = 1;
          m_d = (mode == 2'b10) ? 1 - m_d : ((mode == 2'b01) ? 1 : 0);
        end else if (m_v >= mx) begin
          m_t = 1;
          if (mode == 2'b00) begin m_v = 0; m_d = 0; end
          else begin m_v = mx - 1; m_d = 1; end
        end else if (mode == 2'b00) begin
          m_d = 0; m_v = (m_v + 1) % mx; m_t = (m_v == 0) ? 1 : 0;
        end else if (mode == 2'b01) begin
          m_d = 1; m_v = (m_v + mx - 1) % mx; m_t = (m_v == mx - 1) ? 1 : 0;
        end else if (m_d == 0 && m_v == mx - 1) begin
          m_v = mx - 2; m_d = 1; m_t = 1;
        end else if (m_d == 1 && m_v == 0) begin
          m_v = 1; m_d = 0; m_t = 1;
        end else begin
          m_v = (m_d == 0) ? m_v + 1 : m_v - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if (int'(value) == m_v && int'(dir) == m_d && int'(tc) == m_t) n_pass++;
      else $display("FAIL model t=%0t: value=%0d dir=%0d tc=%0d, required value=%0d dir=%0d tc=%0d",
                    $time, value, dir, tc, m_v, m_d, m_t);
    end
  end

  task automatic drive(input logic e, input logic l, input logic [7:0] lv,
                       input logic [7:0] mx, input logic [1:0] md);
    enable = e; load = l; load_value = lv; max = mx; mode = md;
  endtask

  // One clock later, compare DUT and model against hand-computed values
  task automatic cyc_chk(input string nm, input int v, input int d, input int t);
    @(negedge clk);
    n_checks++;
    if (int'(value) == v && int'(dir) == d && int'(tc) == t) n_pass++;
    else $display("FAIL %s: value=%0d dir=%0d tc=%0d, required value=%0d dir=%0d tc=%0d",
                  nm, value, dir, tc, v, d, t);
    n_checks++;
    if (m_v == v && m_d == d && m_t == t) n_pass++;
    else $display("FAIL %s_model: value=%0d dir=%0d tc=%0d, required value=%0d dir=%0d tc=%0d",
                  nm, m_v, m_d, m_t, v, d, t);
  endtask

  task automatic now_chk(input string nm, input int v, input int d, input int t);
    n_checks++;
    if (int'(value) == v && int'(dir) == d && int'(tc) == t) n_pass++;
    else $display("FAIL %s: value=%0d dir=%0d tc=%0d, required value=%0d dir=%0d tc=%0d",
                  nm, value, dir, tc, v, d, t);
  endtask

  initial begin
    @(negedge clk);
    now_chk("reset_state", 0, 0, 0);
    reset = 1'b0;

    drive(1, 0, 0, 4, 2'b00);
    cyc_chk("up1", 1, 0, 0);
    cyc_chk("up2", 2, 0, 0);
    cyc_chk("up3", 3, 0, 0);
    cyc_chk("up_wrap", 0, 0, 1);
    cyc_chk("up_after", 1, 0, 0);

    drive(0, 1, 0, 3, 2'b01);
    cyc_chk("down_load", 0, 1, 0);
    drive(1, 0, 0, 3, 2'b01);
    cyc_chk("down_wrap", 2, 1, 1);
    cyc_chk("down1", 1, 1, 0);
    cyc_chk("down0", 0, 1, 0);
    cyc_chk("down_wrap2", 2, 1, 1);

    drive(0, 1, 0, 4, 2'b10);
    cyc_chk("pp_load", 0, 0, 0);
    drive(1, 0, 0, 4, 2'b10);
    cyc_chk("pp1", 1, 0, 0);
    cyc_chk("pp2", 2, 0, 0);
    cyc_chk("pp3", 3, 0, 0);
    cyc_chk("pp_rev_top", 2, 1, 1);
    cyc_chk("pp_d1", 1, 1, 0);
    cyc_chk("pp_d0", 0, 1, 0);
    cyc_chk("pp_rev_bot", 1, 0, 1);

    drive(0, 0, 0, 4, 2'b11);
    cyc_chk("idle_tc0", 1, 0, 0);
    drive(1, 0, 0, 4, 2'b11);
    cyc_chk("hold", 1, 0, 0);

    drive(0, 1, 7, 8, 2'b00);
    cyc_chk("load7", 7, 0, 0);
    drive(1, 0, 0, 5, 2'b00);
    cyc_chk("oor_up", 0, 0, 1);
    drive(0, 1, 9, 5, 2'b00);
    cyc_chk("load_oor", 0, 0, 0);
    drive(1, 1, 3, 5, 2'b00);
    cyc_chk("load_beats_step", 3, 0, 0);
    drive(0, 1, 7, 8, 2'b10);
    cyc_chk("load7_pp", 7, 0, 0);
    drive(1, 0, 0, 5, 2'b10);
    cyc_chk("oor_pp", 4, 1, 1);

    drive(1, 0, 0, 0, 2'b00);
    cyc_chk("max0_a", 0, 1, 0);
    cyc_chk("max0_b", 0, 1, 0);

    drive(0, 1, 0, 1, 2'b10);
    cyc_chk("max1_load", 0, 0, 0);
    drive(1, 0, 0, 1, 2'b10);
    cyc_chk("max1_a", 0, 1, 1);
    cyc_chk("max1_b", 0, 0, 1);

    drive(0, 1, 0, 3, 2'b01);
    cyc_chk("pre_rst_load", 0, 1, 0);
    drive(1, 0, 0, 3, 2'b01);
    cyc_chk("pre_rst", 2, 1, 1);
    #2 reset = 1'b1;
    #1 now_chk("async_reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 4, 2'b00);

`ifdef MOD_COUNTER_PRESCALE_EN
    presc = 8'd2;
    drive(0, 1, 0, 4, 2'b00);
    cyc_chk("ps_load", 0, 0, 0);
    drive(1, 0, 0, 4, 2'b00);
    cyc_chk("ps_a", 0, 0, 0);
    cyc_chk("ps_b", 0, 0, 0);
    cyc_chk("ps_c", 1, 0, 0);
    cyc_chk("ps_d", 1, 0, 0);
    drive(1, 1, 2, 4, 2'b00);
    cyc_chk("ps_reload", 2, 0, 0);
    drive(1, 0, 0, 4, 2'b00);
    cyc_chk("ps_e", 2, 0, 0);
    cyc_chk("ps_f", 2, 0, 0);
    cyc_chk("ps_g", 3, 0, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      load   = ($urandom_range(0, 19) == 0);
      load_value = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0)
        max = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
      if ($urandom_range(0, 14) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) presc = 8'($urandom_range(0, 2));
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo counter for rate division and LFO/envelope stepping in the synth datapath. Counts up, down, or ping-pong (triangle) over 0..max-1 under a clock enable, with a runtime modulus, synchronous load and a registered terminal-count pulse. It replaces fixed 8-bit up-only counters wherever width, direction or reversal behaviour is needed.

## Interface
- WIDTH, 8: counter, modulus and load width.
- PRESC_W, 8: prescaler width. Only used with MOD_COUNTER_PRESCALE_EN.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  step request, sampled each clk.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value applied on load.
- max  in  WIDTH  modulus; legal count range is 0..max-1.
- mode  in  2  00 UP, 01 DOWN, 10 PINGPONG, 11 HOLD.
- presc  in  PRESC_W  prescale divisor minus 1. Only present with the macro.
- value  out  WIDTH  current count, registered.
- dir  out  1  0 = counting up, 1 = counting down, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.

## Operation
- Reset values: value=0, dir=0, tc=0, prescaler count=0.
- Priority: reset > load > step > hold.
- step = enable & tick. Without the macro, tick=1.
- load:
  - value <= (max==0 || load_value>=max) ? 0 : load_value.
  - dir <= (mode==DOWN).
  - tc <= 0.
  - Prescaler count cleared.
- max==0: every step holds value at 0, tc=0, dir unchanged.
- max==1: every step leaves value 0 and sets tc=1. PINGPONG also toggles dir.
- Out of range (value>=max, e.g. max lowered at runtime) on a step:
  - UP: value <= 0.
  - DOWN and PINGPONG: value <= max-1, dir <= 1.
  - tc=1 in all three modes.
- UP (dir forced 0):
  - value==max-1: next 0, tc=1.
  - Otherwise value+1, tc=0.
- DOWN (dir forced 1):
  - value==0: next max-1, tc=1.
  - Otherwise value-1, tc=0.
- PINGPONG:
  - dir=0, value==max-1: value <= max-2, dir <= 1, tc=1.
  - dir=1, value==0: value <= 1, dir <= 0, tc=1.
  - Otherwise move one step in direction dir, tc=0.
  - For max>=2 the sequence period is 2*(max-1).
- HOLD: value and dir held. tc=0 on every step.
- Mode change takes effect on the next step. Entering UP or DOWN forces dir on that step.
- tc is 0 on every cycle without a step or load.
- Arithmetic is WIDTH bits. max-1 and max-2 are evaluated only when the guards above exclude underflow.

## Timing
- Step-to-output latency is one clk: value, dir and tc change together on the edge that consumes the step.
- tc is high during the cycle in which value already shows the wrapped or reversed count.
- Async reset clears all outputs immediately, mid-operation included. First step is honoured on the first clk edge after reset deasserts.
- load and enable on the same edge: load wins and the step is discarded.
- No combinational input-to-output paths.

## Configuration
- MOD_COUNTER_PRESCALE_EN defined:
  - presc port and an internal PRESC_W-bit prescaler are present.
  - The prescaler counts enabled cycles. tick=1 when enable=1 and count==presc, and count then returns to 0.
  - presc=0 gives one step per enable.
  - Prescaler count is cleared by reset and by load.
- Undefined: no presc port, no prescaler, every enable is a step.

## Structure
- Shared package mod_counter_pkg:
  - mode enum: MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11.
  - DIR_UP / DIR_DOWN constants.
- One sub-module, mod_counter_prescaler, instantiated only under the macro. It owns the prescale count and the tick output.

## Test plan
- Reset, then UP with max=4 and enable held high: value 0,1,2,3,0,1. tc high only with each 0 after 3.
- DOWN with max=3: value 0,2,1,0,2. tc high with each 2. dir=1 throughout.
- PINGPONG with max=4: value 1,2,3,2,1,0,1. dir flips to 1 with the first 2 and back to 0 with the following 1. tc at both reversals.
- UP at value=7, max changed to 5, one step: value=0, tc=1. Then load_value=9 with max=5: value=0. Then load together with enable, load_value=3: value=3, tc=0.
- Edge moduli: max=0 with steps gives value 0 and tc=0. max=1 in PINGPONG gives value 0, tc=1 every step, dir toggling. Reset asserted mid-count clears value, dir and tc without waiting for clk.
- Macro defined, presc=2, UP with max=4: value advances once every 3 enabled cycles. A load clears the prescaler phase.
